// File: rtl/div_hilo_controller.sv
// Sequencer between the ALU and division_unsigned_32: takes DIV/DIVU requests,
// feeds magnitudes to the divider, sign-corrects its result and owns HI/LO.
module div_hilo_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 128
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_signed,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        req_ready,
   input  logic        wr_hi,
   input  logic        wr_lo,
   input  logic [31:0] wr_data,
   output logic        div_start,
   output logic [31:0] div_operand1,
   output logic [31:0] div_operand2,
   input  logic [63:0] div_result,
   input  logic        div_finish,
   input  logic        div_illegal,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        done,
   output logic        div_by_zero,
   output logic        timeout,
   output logic        wr_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_FIX,
      S_ERR
   } state_t;

   typedef struct packed {
      logic        sign_a;
      logic        sign_b;
      logic [31:0] mag_a;
      logic [31:0] mag_b;
   } op_t;

   state_t        state, state_nx;
   op_t           op_q, op_in;
   logic [CW-1:0] wcnt;
   logic          accept;
   logic          wait_live;
   logic          to_ev;
   logic [31:0]   q, r, fix_hi, fix_lo;

   always_comb begin
      op_in.sign_a = req_signed & req_a[31];
      op_in.sign_b = req_signed & req_b[31];
      op_in.mag_a  = op_in.sign_a ? (~req_a + 32'd1) : req_a;
      op_in.mag_b  = op_in.sign_b ? (~req_b + 32'd1) : req_b;
   end

   assign accept    = req_valid & (state == S_IDLE);
   // the divider's finish/illegal may still be high from the previous op in the first WAIT cycle
   assign wait_live = (wcnt != '0);

   assign q      = div_result[31:0];
   assign r      = div_result[63:32];
   assign fix_lo = (op_q.sign_a ^ op_q.sign_b) ? (~q + 32'd1) : q;
   assign fix_hi = op_q.sign_a ? (~r + 32'd1) : r;

   assign div_operand1 = op_q.mag_a;
   assign div_operand2 = op_q.mag_b;

   always_comb begin
      state_nx  = state;
      to_ev     = 1'b0;
      req_ready = 1'b0;
      div_start = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_nx = (req_b == 32'd0) ? S_ERR : S_LOAD;
         end
         S_LOAD: begin
            div_start = 1'b1;
            state_nx  = S_WAIT;
         end
         S_WAIT: begin
            if (wait_live && div_illegal)
               state_nx = S_ERR;
            else if (wait_live && div_finish)
               state_nx = S_FIX;
            else if (wcnt == CW'(TIMEOUT_CYCLES - 1)) begin
               state_nx = S_IDLE;
               to_ev    = 1'b1;
            end
         end
         S_FIX:   state_nx = S_IDLE;
         S_ERR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         op_q        <= '0;
         wcnt        <= '0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         timeout     <= 1'b0;
         wr_err      <= 1'b0;
      end else begin
         state       <= state_nx;
         done        <= (state == S_FIX) | (state == S_ERR) | to_ev;
         div_by_zero <= (state == S_ERR);
         timeout     <= to_ev;
         wr_err      <= (wr_hi | wr_lo) & (state != S_IDLE);
         wcnt        <= (state == S_WAIT) ? wcnt + CW'(1) : '0;
         if (accept)
            op_q <= op_in;
         // FIX and IDLE are exclusive, so commit and direct writes never collide
         if (state == S_FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
         end else if (state == S_IDLE) begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_div_hilo_controller.sv
// Scoreboard bench for div_hilo_controller with a behavioural divider stub whose
// finish/illegal flags stay high until one cycle after the next start.
module tb_div_hilo_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_signed;
   logic [31:0] req_a, req_b;
   logic        req_ready;
   logic        wr_hi, wr_lo;
   logic [31:0] wr_data;
   logic        div_start;
   logic [31:0] div_operand1, div_operand2;
   logic [63:0] div_result;
   logic        div_finish, div_illegal;
   logic [31:0] hi, lo;
   logic        done, div_by_zero, timeout, wr_err;

   always #5 clock = ~clock;

   div_hilo_controller #(.TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_signed(req_signed), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
      .div_start(div_start), .div_operand1(div_operand1), .div_operand2(div_operand2),
      .div_result(div_result), .div_finish(div_finish), .div_illegal(div_illegal),
      .hi(hi), .lo(lo), .done(done), .div_by_zero(div_by_zero),
      .timeout(timeout), .wr_err(wr_err)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      logic        to;
      int          lat;
   } exp_t;

   exp_t        sbq[$];
   exp_t        me;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] mhi = 32'd0, mlo = 32'd0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // divider stub: mode 0 finishes, 1 hangs, 2 reports illegal, after lat cycles
   int          stub_mode = 0, stub_lat = 2;
   int          mode_q, lat_q, k;
   logic        busy;
   logic [63:0] res_q;

   always @(posedge clock) begin
      if (reset) begin
         busy        <= 1'b0;
         div_finish  <= 1'b0;
         div_illegal <= 1'b0;
         div_result  <= 64'd0;
         k           <= 0;
      end else if (div_start) begin
         busy   <= 1'b1;
         k      <= 0;
         mode_q <= stub_mode;
         lat_q  <= stub_lat;
         res_q  <= (div_operand2 == 32'd0) ? 64'd0 :
                   {div_operand1 % div_operand2, div_operand1 / div_operand2};
      end else if (busy) begin
         k <= k + 1;
         if (k + 1 == 1) begin
            div_finish  <= 1'b0;
            div_illegal <= 1'b0;
         end
         if (k + 1 == lat_q && mode_q != 1) begin
            busy <= 1'b0;
            if (mode_q == 2) div_illegal <= 1'b1;
            else begin
               div_finish <= 1'b1;
               div_result <= res_q;
            end
         end
      end
   end

   // output monitor
   int          cyc = 0, st_cyc = 0, starts = 0;
   logic [31:0] op1_seen, op2_seen;
   logic        done_q = 1'b0;

   always @(negedge clock) begin
      cyc++;
      if (!reset) begin
         if (div_start) begin
            starts++;
            st_cyc   = cyc;
            op1_seen = div_operand1;
            op2_seen = div_operand2;
         end
         if (done) begin
            chk("done_width", done_q, 1'b0);
            if (sbq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               me = sbq.pop_front();
               chk("hi", hi, me.hi);
               chk("lo", lo, me.lo);
               chk("div_by_zero", div_by_zero, me.dbz);
               chk("timeout", timeout, me.to);
               if (me.lat >= 0) chk("latency", cyc - st_cyc, me.lat);
            end
         end
      end
      done_q = done & ~reset;
   end

   task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input int lat);
      exp_t   e;
      longint sa, sb, qq, rr;
      int     s0;
      bit     got;
      e.hi = mhi; e.lo = mlo; e.dbz = 1'b0; e.to = 1'b0; e.lat = lat + 3;
      if (b == 32'd0) begin
         e.dbz = 1'b1; e.lat = -1;
      end else if (mode == 1) begin
         e.to = 1'b1; e.lat = 17;
      end else if (mode == 2) begin
         e.dbz = 1'b1;
      end else begin
         sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
         sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
         qq = sa / sb;
         rr = sa % sb;
         e.lo = qq[31:0];
         e.hi = rr[31:0];
         mhi = e.hi; mlo = e.lo;
      end
      sbq.push_back(e);
      stub_mode = mode; stub_lat = lat; s0 = starts;
      req_valid = 1'b1; req_signed = sgn; req_a = a; req_b = b;
      @(negedge clock);
      req_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (done) begin got = 1'b1; break; end
      end
      if (!got) chk("done_seen", 0, 1);
      chk("start_count", starts - s0, (b == 32'd0) ? 0 : 1);
   endtask

   task automatic wr(input logic h, input logic l, input logic [31:0] d);
      wr_hi = h; wr_lo = l; wr_data = d;
      @(negedge clock);
      wr_hi = 1'b0; wr_lo = 1'b0;
      if (h) mhi = d;
      if (l) mlo = d;
      chk("wr_hi_val", hi, mhi);
      chk("wr_lo_val", lo, mlo);
      chk("wr_err_idle", wr_err, 1'b0);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_a = '0; req_b = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
      repeat (2) @(negedge clock);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_start", div_start, 0);
      chk("rst_ops", {div_operand1, div_operand2}, 0);
      chk("rst_flags", {done, div_by_zero, timeout, wr_err}, 0);
      reset = 1'b0;
      @(negedge clock);

      do_op(1'b0, 32'h1000_0000, 32'h10, 0, 3);
      do_op(1'b0, 32'd2222, 32'd2, 0, 2);
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 4);
      chk("op1_mag", op1_seen, 32'd7);
      chk("op2_mag", op2_seen, 32'd2);

      wr(1'b1, 1'b0, 32'hAA);
      wr(1'b0, 1'b1, 32'hBB);
      do_op(1'b0, 32'd200, 32'd0, 0, 2);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2);
      do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 3);
      wr(1'b1, 1'b1, 32'h55);
      do_op(1'b0, 32'd10, 32'd3, 2, 3);
      for (int i = 0; i < 8; i++)
         do_op(1'(i & 1), $urandom, $urandom_range(40, 1) * ((i % 3 == 0) ? 32'hFFFF_FFFF : 32'd1),
               0, int'($urandom_range(6, 2)));
      do_op(1'b0, 32'd100, 32'd7, 1, 2);

      // abort mid-WAIT: rejected direct write, then reset
      stub_mode = 1; stub_lat = 2;
      req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd50; req_b = 32'd5;
      @(negedge clock);
      req_valid = 1'b0;
      repeat (4) @(negedge clock);
      wr_hi = 1'b1; wr_data = 32'h1234;
      @(negedge clock);
      wr_hi = 1'b0;
      chk("wr_err_busy", wr_err, 1'b1);
      chk("hi_unchanged", hi, mhi);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      mhi = 32'd0; mlo = 32'd0;
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      chk("abort_ready", req_ready, 1);
      chk("abort_start", div_start, 0);
      chk("abort_done", done, 0);

      do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 2);
      repeat (3) @(negedge clock);
      chk("sb_empty", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
